// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue, 4-cycle micro-op sequencer in front of a 2^W x B register file.
// Reads both operands, computes the result, and pulses the file's write port once.
module alu_sequencer #(
    parameter int W = 5,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_rd,
    input  logic [W-1:0] in_rs1,
    input  logic [W-1:0] in_rs2,
    input  logic [B-1:0] in_imm,
    output logic [W-1:0] r_addr_A,
    output logic [W-1:0] r_addr_B,
    input  logic [B-1:0] r_data_A,
    input  logic [B-1:0] r_data_B,
    output logic [W-1:0] w_addr,
    output logic [B-1:0] w_data,
    output logic         wr_en,
    output logic         done,
    output logic         zero_flag,
    output logic         carry_flag
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t       state_q;
    logic [2:0]   op_q;
    logic [W-1:0] rd_q;
    logic [B-1:0] imm_q;
    logic [B-1:0] opa_q;
    logic [B-1:0] opb_q;
    logic         carry_pend_q;

    logic [B:0]   sum_s;
    logic [B:0]   diff_s;
    logic [B-1:0] res_d;
    logic         carry_d;

    // Ready is gated by reset so it reads 0 while reset is held, 1 right after release.
    assign in_ready = (state_q == S_IDLE) && !reset;

    // ALU on the captured operands; bit B of the B+1-bit difference is the borrow.
    always_comb begin
        sum_s   = {1'b0, opa_q} + {1'b0, opb_q};
        diff_s  = {1'b0, opa_q} - {1'b0, opb_q};
        res_d   = w_data;
        carry_d = carry_flag;
        case (op_q)
            OP_ADD: begin
                res_d   = sum_s[B-1:0];
                carry_d = sum_s[B];
            end
            OP_SUB: begin
                res_d   = diff_s[B-1:0];
                carry_d = diff_s[B];
            end
            OP_AND:  res_d = opa_q & opb_q;
            OP_OR:   res_d = opa_q | opb_q;
            OP_XOR:  res_d = opa_q ^ opb_q;
            OP_LDI:  res_d = imm_q;
            OP_MOV:  res_d = opa_q;
            default: res_d = w_data;
        endcase
    end

    // Sequencer FSM with registered read/write-port and flag outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            rd_q         <= {W{1'b0}};
            imm_q        <= {B{1'b0}};
            opa_q        <= {B{1'b0}};
            opb_q        <= {B{1'b0}};
            carry_pend_q <= 1'b0;
            r_addr_A     <= {W{1'b0}};
            r_addr_B     <= {W{1'b0}};
            w_addr       <= {W{1'b0}};
            w_data       <= {B{1'b0}};
            wr_en        <= 1'b0;
            done         <= 1'b0;
            zero_flag    <= 1'b0;
            carry_flag   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        imm_q    <= in_imm;
                        r_addr_A <= in_rs1;
                        r_addr_B <= in_rs2;
                        state_q  <= S_READ;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_READ: begin
                    opa_q   <= r_data_A;
                    opb_q   <= r_data_B;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q != OP_NOP) begin
                        w_addr <= rd_q;
                        w_data <= res_d;
                        wr_en  <= 1'b1;
                    end else begin
                        wr_en  <= 1'b0;
                    end
                    carry_pend_q <= carry_d;
                    done         <= 1'b1;
                    state_q      <= S_WRITE;
                end
                S_WRITE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    if (op_q != OP_NOP) begin
                        zero_flag <= (w_data == {B{1'b0}});
                    end else begin
                        zero_flag <= zero_flag;
                    end
                    if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                        carry_flag <= carry_pend_q;
                    end else begin
                        carry_flag <= carry_flag;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed plan plus random ops against an
// instruction-level reference of the register file and flags.
module tb_alu_sequencer;
    localparam int W = 5;
    localparam int B = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_rd, in_rs1, in_rs2;
    logic [B-1:0] in_imm;
    logic [W-1:0] r_addr_A, r_addr_B, w_addr;
    logic [B-1:0] r_data_A, r_data_B, w_data;
    logic         wr_en, done, zero_flag, carry_flag;

    logic [B-1:0] rf     [0:31];
    logic [B-1:0] ref_rf [0:31];
    logic         ref_z, ref_c;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.W(W), .B(B)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .r_addr_A(r_addr_A), .r_addr_B(r_addr_B), .r_data_A(r_data_A), .r_data_B(r_data_B),
        .w_addr(w_addr), .w_data(w_data), .wr_en(wr_en), .done(done),
        .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    // Register file model: asynchronous reads, write on the rising edge.
    assign r_data_A = rf[r_addr_A];
    assign r_data_B = rf[r_addr_B];
    always @(posedge clk) if (wr_en) rf[w_addr] <= w_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction at a falling edge and follow it through every phase.
    task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                         input logic [7:0] imm, input bit hold);
        int a, b, s;
        logic [7:0] res;
        bit c, wr;
        for (int i = 0; i < 8 && !in_ready; i++) @(negedge clk);
        check("ready_before_issue", in_ready, 1);
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        wr = 1'b1;
        c = ref_c;
        res = 8'h00;
        case (op)
            3'd0: begin s = a + b; res = 8'(s % 256); c = (s > 255); end
            3'd1: begin res = 8'((a - b + 256) % 256); c = (a < b); end
            3'd2: res = 8'(a & b);
            3'd3: res = 8'(a | b);
            3'd4: res = 8'(a ^ b);
            3'd5: res = imm;
            3'd6: res = 8'(a);
            default: wr = 1'b0;
        endcase
        in_valid = 1'b1; in_op = op; in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
        @(negedge clk);
        if (hold) begin
            in_op = 3'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
            in_rs2 = 5'($urandom); in_imm = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        check("read_ready", in_ready, 0);
        check("read_addr_A", r_addr_A, 32'(rs1));
        check("read_addr_B", r_addr_B, 32'(rs2));
        check("read_wr_en", wr_en, 0);
        @(negedge clk);
        check("exec_ready", in_ready, 0);
        check("exec_wr_en", wr_en, 0);
        check("exec_done", done, 0);
        @(negedge clk);
        check("write_ready", in_ready, 0);
        check("write_done", done, 1);
        check("write_wr_en", wr_en, 32'(wr));
        if (wr) begin
            check("write_addr", w_addr, 32'(rd));
            check("write_data", w_data, 32'(res));
        end
        @(negedge clk);
        if (wr) begin
            ref_rf[rd] = res;
            ref_z = (res == 8'h00);
        end
        if (op <= 3'd1) ref_c = c;
        check("idle_ready", in_ready, 1);
        check("idle_wr_en", wr_en, 0);
        check("idle_done", done, 0);
        check("zero_flag", zero_flag, 32'(ref_z));
        check("carry_flag", carry_flag, 32'(ref_c));
        if (wr) check("rf_update", rf[rd], 32'(ref_rf[rd]));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_op = 3'd5; in_rd = 5'd1;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 8'hAA;
        ref_z = 1'b0; ref_c = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 8'h00;
        @(negedge clk); @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_r_addr_A", r_addr_A, 0);
        check("rst_r_addr_B", r_addr_B, 0);
        check("rst_zero", zero_flag, 0);
        check("rst_carry", carry_flag, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1 check("post_rst_ready", in_ready, 1);

        // Fill the whole file first so every later read has a known value.
        for (int r = 0; r < 32; r++) issue(3'd5, r, 0, 0, 8'($urandom), 1'b0);

        issue(3'd5, 3, 0, 0, 8'h7F, 1'b0);
        issue(3'd5, 4, 0, 0, 8'h81, 1'b0);
        issue(3'd0, 5, 3, 4, 8'h00, 1'b0);
        check("add_wrap_zero", zero_flag, 1);
        check("add_carry", carry_flag, 1);
        issue(3'd1, 6, 4, 3, 8'h00, 1'b0);
        check("sub_result", rf[6], 32'h02);
        check("sub_no_borrow", carry_flag, 0);
        issue(3'd1, 7, 3, 4, 8'h00, 1'b0);
        check("sub_wrap", rf[7], 32'hFE);
        check("sub_borrow", carry_flag, 1);
        issue(3'd6, 8, 6, 0, 8'h00, 1'b0);
        issue(3'd4, 9, 8, 6, 8'h00, 1'b0);
        check("dep_chain_xor", rf[9], 32'h00);

        // Continuous in_valid: one acceptance per 4 cycles, fields ignored while busy.
        issue(3'd2, 11, 3, 4, 8'h00, 1'b1);
        issue(3'd3, 12, 3, 4, 8'h00, 1'b1);
        issue(3'd7, 13, 3, 4, 8'h00, 1'b1);
        in_valid = 1'b0;

        // Reset during EXEC of ADD rd=10 must discard it.
        issue(3'd5, 10, 0, 0, 8'h55, 1'b0);
        in_valid = 1'b1; in_op = 3'd0; in_rd = 5'd10; in_rs1 = 5'd3; in_rs2 = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        in_valid = 1'b1;
        #1 check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        check("mid_rst_wr_en_hold", wr_en, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        ref_z = 1'b0; ref_c = 1'b0;
        #1 check("mid_rst_release_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_write", wr_en, 0);
        end
        check("mid_rst_r10", rf[10], 32'(ref_rf[10]));
        check("mid_rst_zero", zero_flag, 0);
        check("mid_rst_carry", carry_flag, 0);
        issue(3'd0, 14, 3, 3, 8'h00, 1'b0);

        for (int n = 0; n < 60; n++)
            issue(3'($urandom), int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                  int'($urandom_range(31, 0)), 8'($urandom), bit'($urandom_range(1, 0)));
        in_valid = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 32; r++) check("final_rf", rf[r], 32'(ref_rf[r]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
